// File: rtl/batch_loader.sv
// batch_loader: packs a valid/ready sample stream into a parallel batch array.
// It announces each finished batch with a one-cycle input_ready pulse and holds
// the batch stable until the forward stage returns output_taken.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   in_data/in_valid  streamed signed fixed-point sample
//   in_last           marks the final sample of a batch
//   in_ready          loader accepts a sample this cycle (FILL state)
//   batch             packed batch, entry 0 = first sample
//   num               number of valid entries in batch
//   input_ready       one-cycle "batch available" pulse
//   output_taken      forward stage releases the batch
//   forced            batch was closed by reaching size without in_last
//   state             current FSM state, for debug
module batch_loader #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int size = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IL+FL-1:0]     in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic signed [IL+FL-1:0]     batch [size],
    output logic [$clog2(size+1)-1:0]   num,
    output logic                        input_ready,
    input  logic                        output_taken,
    output logic                        forced,
    output logic [1:0]                  state
);

    localparam int unsigned IW = $clog2(size);
    localparam int unsigned NW = $clog2(size + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(size - 1);

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx;
    logic          at_end;
    logic          close;

    assign at_end = (idx == LAST_IDX);
    // A batch closes on the accepting edge of either in_last or the size-th sample.
    assign close  = in_valid && (in_last || at_end);

    // Handshake outputs decode the registered state only.
    assign in_ready    = (state_q == FILL);
    assign input_ready = (state_q == ISSUE);
    assign state       = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding falls back to FILL.
    always_comb begin
        state_d = FILL;
        case (state_q)
            FILL:    state_d = close ? ISSUE : FILL;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = output_taken ? FILL : WAIT;
            default: state_d = FILL;
        endcase
    end

    // Batch storage, write index, count and forced flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < size; i++) batch[i] <= '0;
            num    <= '0;
            idx    <= '0;
            forced <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        batch[idx] <= in_data;
                        if (close) begin
                            // idx is held on close so it never wraps past size-1.
                            num    <= NW'(idx) + NW'(1);
                            forced <= at_end && !in_last;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (output_taken) begin
                        for (int i = 0; i < size; i++) batch[i] <= '0;
                        num    <= '0;
                        idx    <= '0;
                        forced <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_batch_loader.sv
// Testbench for batch_loader: table-driven cycle vectors plus directed
// sequences for forced close, back-to-back streaming and asynchronous reset.
module tb_batch_loader;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int SIZE = 16;
    localparam int DW   = IL + FL;
    localparam int NW   = $clog2(SIZE + 1);

    logic                 clk;
    logic                 reset;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic signed [DW-1:0] batch [SIZE];
    logic [NW-1:0]        num;
    logic                 input_ready;
    logic                 output_taken;
    logic                 forced;
    logic [1:0]           state;

    int checks = 0;
    int errors = 0;

    batch_loader #(.IL(IL), .FL(FL), .size(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .batch        (batch),
        .num          (num),
        .input_ready  (input_ready),
        .output_taken (output_taken),
        .forced       (forced),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 valid;
        logic                 last;
        logic                 taken;
        logic [1:0]           st;
        int                   n;
        logic                 ir;
        logic                 inr;
        logic                 frc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // One clock, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_last      = 1'b0;
        output_taken = 1'b0;
        in_data      = '0;
    endtask

    task automatic send(input int d, input logic last);
        in_data  = DW'(d);
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        output_taken = 1'b1;
        step();
        output_taken = 1'b0;
    endtask

    task automatic check_zero_from(input string tag, input int from);
        for (int j = from; j < SIZE; j++)
            check($sformatf("%s.batch[%0d]", tag, j), 32'(batch[j]), 0);
    endtask

    function automatic vec_t mk(input int d, input logic v, input logic l, input logic t,
                                input logic [1:0] s, input int n, input logic ir,
                                input logic inr, input logic f);
        vec_t r;
        r.data = DW'(d); r.valid = v; r.last = l; r.taken = t;
        r.st = s; r.n = n; r.ir = ir; r.inr = inr; r.frc = f;
        return r;
    endfunction

    int next_val;
    int base;
    int issued;
    int sz;
    logic acc;
    int sizes [2];

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Batch of 0..9, output_taken during FILL (ignored), sample offered in WAIT (ignored).
        for (int i = 0; i < 10; i++) begin
            if (i < 9) vecs.push_back(mk(i, 1, 0, (i == 3), 2'b00, 0, 0, 1, 0));
            else       vecs.push_back(mk(i, 1, 1, 0, 2'b01, 10, 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 2'b10, 10, 0, 0, 0));
        vecs.push_back(mk(99, 1, 1, 0, 2'b10, 10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b10, 10, 0, 0, 0));

        // Reset state.
        #12;
        check("rst.state", 32'(state), 0);
        check("rst.num", 32'(num), 0);
        check("rst.in_ready", 32'(in_ready), 1);
        check("rst.input_ready", 32'(input_ready), 0);
        check("rst.forced", 32'(forced), 0);
        check_zero_from("rst", 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        foreach (vecs[k]) begin
            in_data = vecs[k].data; in_valid = vecs[k].valid;
            in_last = vecs[k].last; output_taken = vecs[k].taken;
            step();
            check($sformatf("vec%0d.state", k), 32'(state), 32'(vecs[k].st));
            check($sformatf("vec%0d.num", k), 32'(num), vecs[k].n);
            check($sformatf("vec%0d.input_ready", k), 32'(input_ready), 32'(vecs[k].ir));
            check($sformatf("vec%0d.in_ready", k), 32'(in_ready), 32'(vecs[k].inr));
            check($sformatf("vec%0d.forced", k), 32'(forced), 32'(vecs[k].frc));
        end
        idle_inputs();
        for (int j = 0; j < 10; j++) check($sformatf("b10.batch[%0d]", j), 32'(batch[j]), j);
        check_zero_from("b10", 10);

        // Release, then a single-sample batch of -3.0.
        take();
        check("rel.state", 32'(state), 0);
        check("rel.num", 32'(num), 0);
        check_zero_from("rel", 0);
        send(-196608, 1'b1);
        check("one.num", 32'(num), 1);
        check("one.input_ready", 32'(input_ready), 1);
        check("one.batch0", 32'(batch[0]), -196608);
        check_zero_from("one", 1);
        step();
        take();

        // 17 samples without in_last: 16 stored and forced, 17th held until release.
        for (int i = 0; i < 16; i++) send(100 + i, 1'b0);
        check("frc.state", 32'(state), 1);
        check("frc.num", 32'(num), 16);
        check("frc.forced", 32'(forced), 1);
        check("frc.in_ready", 32'(in_ready), 0);
        in_data = DW'(116); in_valid = 1'b1; in_last = 1'b1;
        step(); step();
        check("frc.hold.state", 32'(state), 2);
        check("frc.hold.num", 32'(num), 16);
        for (int j = 0; j < SIZE; j++) check($sformatf("frc.batch[%0d]", j), 32'(batch[j]), 100 + j);
        output_taken = 1'b1;
        step();
        output_taken = 1'b0;
        check("frc.rel.state", 32'(state), 0);
        check("frc.rel.forced", 32'(forced), 0);
        check("frc.rel.num", 32'(num), 0);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("s17.num", 32'(num), 1);
        check("s17.batch0", 32'(batch[0]), 116);
        check("s17.forced", 32'(forced), 0);
        step();
        take();

        // 16 samples with in_last on the 16th: full but not forced.
        for (int i = 0; i < 16; i++) send(200 + i, (i == 15));
        check("full.num", 32'(num), 16);
        check("full.forced", 32'(forced), 0);
        check("full.batch15", 32'(batch[15]), 215);
        step();
        take();

        // Continuous in_valid across batches of 3 and 5; release as soon as WAIT is seen.
        sizes[0] = 3; sizes[1] = 5;
        next_val = 0; base = 0; issued = 0;
        for (int cyc = 0; cyc < 60 && issued < 2; cyc++) begin
            sz = sizes[issued];
            in_valid = 1'b1;
            in_data  = DW'(1000 + next_val);
            in_last  = (next_val - base == sz - 1);
            output_taken = (state == 2'b10);
            acc = (state == 2'b00);
            check($sformatf("str%0d.in_ready", cyc), 32'(in_ready), 32'(acc));
            step();
            if (acc) next_val++;
            if (input_ready) begin
                check($sformatf("str.b%0d.num", issued), 32'(num), sz);
                for (int j = 0; j < sz; j++)
                    check($sformatf("str.b%0d[%0d]", issued, j), 32'(batch[j]), 1000 + base + j);
                base += sz;
                issued++;
            end
        end
        idle_inputs();
        check("str.issued", issued, 2);
        check("str.sent", next_val, 8);

        // Asynchronous reset in WAIT.
        step();
        check("rw.pre.state", 32'(state), 2);
        #2 reset = 1'b0;
        #1;
        check("rw.state", 32'(state), 0);
        check("rw.num", 32'(num), 0);
        check("rw.input_ready", 32'(input_ready), 0);
        check_zero_from("rw", 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Asynchronous reset mid-FILL after 5 samples, then restart at index 0.
        for (int i = 0; i < 5; i++) send(300 + i, 1'b0);
        check("rf.pre.batch4", 32'(batch[4]), 304);
        #2 reset = 1'b0;
        #1;
        check("rf.state", 32'(state), 0);
        check("rf.num", 32'(num), 0);
        check("rf.input_ready", 32'(input_ready), 0);
        check_zero_from("rf", 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        send(400, 1'b0);
        send(401, 1'b1);
        check("rf.new.num", 32'(num), 2);
        check("rf.new.batch0", 32'(batch[0]), 400);
        check("rf.new.batch1", 32'(batch[1]), 401);
        check_zero_from("rf.new", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
